vp_stride_table: RTL and testbench

// Multi-lane, direct-mapped, tagged stride/last-value predictor. It is the first

---
 rtl/vp_stride_table.sv | 158 +++++++++++++++
 tb/tb_vp_stride_table.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vp_stride_table.sv
// Direct-mapped, tagged stride/last-value predictor with N lookup and N training lanes.
// Predictions are registered (1-cycle latency); an init sweep clears the table after reset or flush.
module vp_stride_table #(
    parameter int    P_NUM_PRED   = 2,
    parameter int    P_ENTRIES    = 256,
    parameter int    P_TAG_WIDTH  = 8,
    parameter int    P_CONF_WIDTH = 3,
    parameter string P_MODE       = "STRIDE"
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    output logic                         ready_o,
    input  logic [P_NUM_PRED-1:0][31:0]  fw_pc_i,
    input  logic [P_NUM_PRED-1:0]        fw_valid_i,
    output logic [P_NUM_PRED-1:0][31:0]  pred_pc_o,
    output logic [P_NUM_PRED-1:0][31:0]  pred_result_o,
    output logic [P_NUM_PRED-1:0]        pred_conf_o,
    output logic [P_NUM_PRED-1:0]        pred_valid_o,
    input  logic [P_NUM_PRED-1:0][31:0]  fb_pc_i,
    input  logic [P_NUM_PRED-1:0][31:0]  fb_actual_i,
    input  logic [P_NUM_PRED-1:0]        fb_valid_i
);

    localparam int                      IDXW        = $clog2(P_ENTRIES);
    localparam bit                      STRIDE_MODE = (P_MODE == "STRIDE");
    localparam logic [IDXW-1:0]         LAST_IDX    = IDXW'(P_ENTRIES - 1);
    localparam logic [P_CONF_WIDTH-1:0] CMAX        = '1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   cnt_q, cnt_d;

    logic                    valid_q  [P_ENTRIES];
    logic [P_TAG_WIDTH-1:0]  tag_q    [P_ENTRIES];
    logic [31:0]             last_q   [P_ENTRIES];
    logic [31:0]             stride_q [P_ENTRIES];
    logic [P_CONF_WIDTH-1:0] conf_q   [P_ENTRIES];

    logic [IDXW-1:0]         fb_idx    [P_NUM_PRED];
    logic [31:0]             fb_stride [P_NUM_PRED];
    logic [P_CONF_WIDTH-1:0] fb_conf   [P_NUM_PRED];

    logic [P_NUM_PRED-1:0][31:0] pred_pc_d, pred_result_d;
    logic [P_NUM_PRED-1:0]       pred_conf_d, pred_valid_d;

    // Only the index and tag slices of the feedback PC select an entry.
    logic unused_fb_pc;
    assign unused_fb_pc = ^fb_pc_i;

    assign ready_o = (state_q == ST_RUN);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + IDXW'(1);
                if (cnt_q == LAST_IDX) state_d = ST_RUN;
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
        if (flush_i) begin
            state_d = ST_INIT;
            cnt_d   = '0;
        end
    end

    // Training: next stride/confidence per lane, computed from pre-update table contents.
    always_comb begin
        logic [IDXW-1:0] idx;
        logic [31:0]     delta;
        logic            match;
        for (int l = 0; l < P_NUM_PRED; l++) begin
            idx          = fb_pc_i[l][2 +: IDXW];
            delta        = '0;
            match        = 1'b0;
            fb_idx[l]    = idx;
            fb_stride[l] = '0;
            fb_conf[l]   = '0;
            if (valid_q[idx] && (tag_q[idx] == fb_pc_i[l][2+IDXW +: P_TAG_WIDTH])) begin
                delta = fb_actual_i[l] - last_q[idx];
                match = STRIDE_MODE ? (delta == stride_q[idx]) : (fb_actual_i[l] == last_q[idx]);
                if (match) begin
                    fb_stride[l] = stride_q[idx];
                    fb_conf[l]   = (conf_q[idx] == CMAX) ? CMAX : conf_q[idx] + P_CONF_WIDTH'(1);
                end else begin
                    fb_stride[l] = delta;
                end
            end
        end
    end

    // Later lanes overwrite earlier ones, so the highest lane wins an index collision.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_INIT) begin
            valid_q[cnt_q] <= 1'b0;
        end else if (rst_ni) begin
            for (int l = 0; l < P_NUM_PRED; l++) begin
                if (fb_valid_i[l]) begin
                    valid_q[fb_idx[l]]  <= 1'b1;
                    tag_q[fb_idx[l]]    <= fb_pc_i[l][2+IDXW +: P_TAG_WIDTH];
                    last_q[fb_idx[l]]   <= fb_actual_i[l];
                    stride_q[fb_idx[l]] <= fb_stride[l];
                    conf_q[fb_idx[l]]   <= fb_conf[l];
                end
            end
        end
    end

    always_comb begin
        logic [IDXW-1:0] idx;
        for (int l = 0; l < P_NUM_PRED; l++) begin
            idx              = fw_pc_i[l][2 +: IDXW];
            pred_valid_d[l]  = 1'b0;
            pred_pc_d[l]     = '0;
            pred_result_d[l] = '0;
            pred_conf_d[l]   = 1'b0;
            if ((state_q == ST_RUN) && fw_valid_i[l] && valid_q[idx] &&
                (tag_q[idx] == fw_pc_i[l][2+IDXW +: P_TAG_WIDTH])) begin
                pred_valid_d[l]  = 1'b1;
                pred_pc_d[l]     = fw_pc_i[l];
                pred_result_d[l] = STRIDE_MODE ? last_q[idx] + stride_q[idx] : last_q[idx];
                pred_conf_d[l]   = (conf_q[idx] == CMAX);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pred_valid_o  <= '0;
            pred_pc_o     <= '0;
            pred_result_o <= '0;
            pred_conf_o   <= '0;
        end else begin
            pred_valid_o  <= pred_valid_d;
            pred_pc_o     <= pred_pc_d;
            pred_result_o <= pred_result_d;
            pred_conf_o   <= pred_conf_d;
        end
    end

endmodule

// File: tb/tb_vp_stride_table.sv
// Scoreboard bench for vp_stride_table: a STRIDE-mode and a LAST-mode instance, 16 entries, 2-bit confidence.
// Stimulus pushes the hand-computed prediction per lookup; monitors pop and compare one cycle later.
module tb_vp_stride_table;

    typedef struct {
        logic        vld;
        logic [31:0] pc;
        logic [31:0] res;
        logic        conf;
    } exp_t;

    logic clk;
    logic rst_n;
    logic flush;

    logic             a_ready;
    logic [1:0][31:0] a_fw_pc, a_pred_pc, a_pred_res, a_fb_pc, a_fb_act;
    logic [1:0]       a_fw_valid, a_pred_conf, a_pred_valid, a_fb_valid;

    logic             l_ready;
    logic [1:0][31:0] l_fw_pc, l_pred_pc, l_pred_res, l_fb_pc, l_fb_act;
    logic [1:0]       l_fw_valid, l_pred_conf, l_pred_valid, l_fb_valid;

    exp_t exp_q[$];
    exp_t expl_q[$];
    int   n_compared;
    int   n_mismatched;

    vp_stride_table #(
        .P_NUM_PRED(2), .P_ENTRIES(16), .P_TAG_WIDTH(8), .P_CONF_WIDTH(2), .P_MODE("STRIDE")
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .ready_o(a_ready),
        .fw_pc_i(a_fw_pc), .fw_valid_i(a_fw_valid),
        .pred_pc_o(a_pred_pc), .pred_result_o(a_pred_res), .pred_conf_o(a_pred_conf),
        .pred_valid_o(a_pred_valid),
        .fb_pc_i(a_fb_pc), .fb_actual_i(a_fb_act), .fb_valid_i(a_fb_valid)
    );

    vp_stride_table #(
        .P_NUM_PRED(2), .P_ENTRIES(16), .P_TAG_WIDTH(8), .P_CONF_WIDTH(2), .P_MODE("LAST")
    ) dut_last (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .ready_o(l_ready),
        .fw_pc_i(l_fw_pc), .fw_valid_i(l_fw_valid),
        .pred_pc_o(l_pred_pc), .pred_result_o(l_pred_res), .pred_conf_o(l_pred_conf),
        .pred_valid_o(l_pred_valid),
        .fb_pc_i(l_fb_pc), .fb_actual_i(l_fb_act), .fb_valid_i(l_fb_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic v, input logic [31:0] pc,
                                input logic [31:0] res, input logic conf, input exp_t e);
        n_compared++;
        if (v !== e.vld || pc !== e.pc || res !== e.res || conf !== e.conf) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got valid=%0b pc=%h result=%h conf=%0b, expected valid=%0b pc=%h result=%h conf=%0b",
                     name, v, pc, res, conf, e.vld, e.pc, e.res, e.conf);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    task automatic make_exp(input logic [31:0] pc, input logic ev, input logic [31:0] eres,
                            input logic econf, output exp_t e);
        e.vld  = ev;
        e.pc   = ev ? pc : 32'h0;
        e.res  = ev ? eres : 32'h0;
        e.conf = ev & econf;
    endtask

    task automatic lookup(input int lane, input logic [31:0] pc, input logic ev,
                          input logic [31:0] eres, input logic econf);
        exp_t e;
        a_fw_valid[lane] = 1'b1;
        a_fw_pc[lane]    = pc;
        make_exp(pc, ev, eres, econf, e);
        exp_q.push_back(e);
    endtask

    task automatic feedback(input int lane, input logic [31:0] pc, input logic [31:0] act);
        a_fb_valid[lane] = 1'b1;
        a_fb_pc[lane]    = pc;
        a_fb_act[lane]   = act;
    endtask

    task automatic lookup_last(input logic [31:0] pc, input logic ev,
                               input logic [31:0] eres, input logic econf);
        exp_t e;
        l_fw_valid[0] = 1'b1;
        l_fw_pc[0]    = pc;
        make_exp(pc, ev, eres, econf, e);
        expl_q.push_back(e);
    endtask

    task automatic feedback_last(input logic [31:0] pc, input logic [31:0] act);
        l_fb_valid[0] = 1'b1;
        l_fb_pc[0]    = pc;
        l_fb_act[0]   = act;
    endtask

    // One clock: inputs set beforehand are sampled at this edge, then valids drop.
    task automatic apply_stimulus();
        @(posedge clk);
        #1;
        a_fw_valid = '0;
        a_fb_valid = '0;
        l_fw_valid = '0;
        l_fb_valid = '0;
    endtask

    task automatic check_init_sweep(input string name);
        for (int i = 0; i < 16; i++) begin
            check_bit({name, " ready low"}, a_ready, 1'b0);
            lookup(0, 32'h0000_0208, 1'b0, 32'h0, 1'b0);
            apply_stimulus();
        end
        check_bit({name, " ready high"}, a_ready, 1'b1);
        check_bit({name, " ready high (LAST)"}, l_ready, 1'b1);
    endtask

    initial begin : mon_a
        logic [1:0] issued;
        exp_t       e;
        forever begin
            @(posedge clk);
            issued = a_fw_valid;
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                if (issued[l]) begin
                    if (exp_q.size() == 0) begin
                        n_compared++;
                        n_mismatched++;
                        $display("[TB] FAIL stride lookup lane%0d: got valid=%0b, expected a queued entry", l, a_pred_valid[l]);
                    end else begin
                        e = exp_q.pop_front();
                        check_output($sformatf("stride lookup lane%0d", l), a_pred_valid[l],
                                     a_pred_pc[l], a_pred_res[l], a_pred_conf[l], e);
                    end
                end else if (a_pred_valid[l] === 1'b1) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL stride spurious lane%0d: got valid=1, expected 0", l);
                end
            end
        end
    end

    initial begin : mon_l
        logic [1:0] issued;
        exp_t       e;
        forever begin
            @(posedge clk);
            issued = l_fw_valid;
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                if (issued[l]) begin
                    if (expl_q.size() == 0) begin
                        n_compared++;
                        n_mismatched++;
                        $display("[TB] FAIL last lookup lane%0d: got valid=%0b, expected a queued entry", l, l_pred_valid[l]);
                    end else begin
                        e = expl_q.pop_front();
                        check_output($sformatf("last lookup lane%0d", l), l_pred_valid[l],
                                     l_pred_pc[l], l_pred_res[l], l_pred_conf[l], e);
                    end
                end else if (l_pred_valid[l] === 1'b1) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL last spurious lane%0d: got valid=1, expected 0", l);
                end
            end
        end
    end

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        a_fw_pc = '0; a_fw_valid = '0; a_fb_pc = '0; a_fb_act = '0; a_fb_valid = '0;
        l_fw_pc = '0; l_fw_valid = '0; l_fb_pc = '0; l_fb_act = '0; l_fb_valid = '0;

        // Reset, then the 16-cycle init sweep; lookups and feedback are ignored meanwhile.
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_bit("pred_valid after reset", |a_pred_valid, 1'b0);
        check_bit("pred_pc zero after reset", |a_pred_pc, 1'b0);
        for (int i = 0; i < 16; i++) begin
            check_bit("ready during init", a_ready, 1'b0);
            lookup(0, 32'h0000_0000, 1'b0, 32'h0, 1'b0);
            lookup(1, 32'h0000_0104, 1'b0, 32'h0, 1'b0);
            if (i >= 12) feedback(0, 32'h0000_0104, 32'd55);
            apply_stimulus();
        end
        check_bit("ready after init sweep", a_ready, 1'b1);
        check_bit("ready after init sweep (LAST)", l_ready, 1'b1);

        // First training allocates with stride 0.
        feedback(0, 32'h0000_0100, 32'd10);
        apply_stimulus();
        lookup(0, 32'h0000_0100, 1'b1, 32'd10, 1'b0);
        lookup(1, 32'h0000_0104, 1'b0, 32'h0, 1'b0);
        apply_stimulus();

        // Stride training; the same-cycle lookup sees the pre-write entry.
        feedback(0, 32'h0000_0040, 32'd10); apply_stimulus();
        feedback(1, 32'h0000_0040, 32'd20); apply_stimulus();
        feedback(0, 32'h0000_0040, 32'd30); apply_stimulus();
        lookup(0, 32'h0000_0040, 1'b1, 32'd40, 1'b0);
        feedback(1, 32'h0000_0040, 32'd40);
        apply_stimulus();
        feedback(0, 32'h0000_0040, 32'd50); apply_stimulus();
        lookup(1, 32'h0000_0040, 1'b1, 32'd60, 1'b1);
        apply_stimulus();
        feedback(0, 32'h0000_0040, 32'd99); apply_stimulus();
        lookup(0, 32'h0000_0040, 1'b1, 32'd148, 1'b0);
        lookup(1, 32'h0000_0100, 1'b0, 32'h0, 1'b0);
        apply_stimulus();

        // Confidence saturates at 3 rather than wrapping.
        for (int k = 1; k <= 5; k++) begin
            feedback(0, 32'h0000_0040, 32'd99 + 32'd49 * k);
            apply_stimulus();
        end
        lookup(0, 32'h0000_0040, 1'b1, 32'd393, 1'b1);
        apply_stimulus();

        // Stride across the 32-bit wrap.
        feedback(1, 32'h0000_0044, 32'hFFFF_FFFF); apply_stimulus();
        feedback(1, 32'h0000_0044, 32'h0000_0001); apply_stimulus();
        lookup(1, 32'h0000_0044, 1'b1, 32'h0000_0003, 1'b0);
        apply_stimulus();

        // LAST mode: repeated value builds confidence; stride is never added.
        for (int k = 0; k < 4; k++) begin
            feedback_last(32'h0000_0080, 32'd7);
            apply_stimulus();
        end
        lookup_last(32'h0000_0080, 1'b1, 32'd7, 1'b1);
        apply_stimulus();
        feedback_last(32'h0000_0080, 32'd9); apply_stimulus();
        lookup_last(32'h0000_0080, 1'b1, 32'd9, 1'b0);
        apply_stimulus();

        // Alias on the same index replaces the older tag.
        feedback(0, 32'h0000_0100, 32'd1); apply_stimulus();
        feedback(0, 32'h0000_0140, 32'd2); apply_stimulus();
        lookup(0, 32'h0000_0100, 1'b0, 32'h0, 1'b0);
        lookup(1, 32'h0000_0140, 1'b1, 32'd2, 1'b0);
        apply_stimulus();

        // Lane collision: lane 1 wins; distinct indices both commit.
        feedback(0, 32'h0000_0200, 32'd5);
        feedback(1, 32'h0000_0200, 32'd7);
        lookup(0, 32'h0000_0200, 1'b0, 32'h0, 1'b0);
        apply_stimulus();
        lookup(1, 32'h0000_0200, 1'b1, 32'd7, 1'b0);
        apply_stimulus();
        feedback(0, 32'h0000_0200, 32'd9);
        feedback(1, 32'h0000_0200, 32'd11);
        apply_stimulus();
        lookup(0, 32'h0000_0200, 1'b1, 32'd15, 1'b0);
        apply_stimulus();
        feedback(0, 32'h0000_0208, 32'd3);
        feedback(1, 32'h0000_020C, 32'd4);
        apply_stimulus();
        lookup(0, 32'h0000_0208, 1'b1, 32'd3, 1'b0);
        lookup(1, 32'h0000_020C, 1'b1, 32'd4, 1'b0);
        apply_stimulus();

        // Flush in RUN re-runs the sweep and invalidates everything.
        flush = 1'b1;
        apply_stimulus();
        flush = 1'b0;
        check_init_sweep("flush sweep");
        lookup(0, 32'h0000_0208, 1'b0, 32'h0, 1'b0);
        lookup(1, 32'h0000_020C, 1'b0, 32'h0, 1'b0);
        apply_stimulus();
        lookup(0, 32'h0000_0200, 1'b0, 32'h0, 1'b0);
        lookup(1, 32'h0000_0040, 1'b0, 32'h0, 1'b0);
        apply_stimulus();
        lookup_last(32'h0000_0080, 1'b0, 32'h0, 1'b0);
        apply_stimulus();

        // Reset in the middle of a sweep restarts it from index 0.
        feedback(0, 32'h0000_0208, 32'd3); apply_stimulus();
        flush = 1'b1;
        apply_stimulus();
        flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_bit("ready mid-sweep", a_ready, 1'b0);
            apply_stimulus();
        end
        rst_n = 1'b0;
        lookup(0, 32'h0000_0208, 1'b0, 32'h0, 1'b0);
        apply_stimulus();
        rst_n = 1'b1;
        check_init_sweep("reset sweep");
        feedback(0, 32'h0000_0208, 32'd8); apply_stimulus();
        lookup(0, 32'h0000_0208, 1'b1, 32'd8, 1'b0);
        apply_stimulus();

        repeat (3) apply_stimulus();
        check_bit("stride scoreboard drained", exp_q.size() == 0, 1'b1);
        check_bit("last scoreboard drained", expl_q.size() == 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
